// File: rtl/sigma_timer_pkg.sv
// Shared definitions for the sigma xif timer: register map, CTRL layout,
// counter run state and the byte-lane write merge helper.
package sigma_timer_pkg;

   localparam logic [3:0] OFS_CTRL   = 4'h0;
   localparam logic [3:0] OFS_LOAD   = 4'h4;
   localparam logic [3:0] OFS_COUNT  = 4'h8;
   localparam logic [3:0] OFS_STATUS = 4'hC;

   localparam int unsigned CTRL_EN         = 0;
   localparam int unsigned CTRL_AUTORELOAD = 1;
   localparam int unsigned CTRL_IRQ_EN     = 2;
   localparam int unsigned CTRL_PS_LSB     = 8;
   localparam int unsigned CTRL_PS_MSB     = 15;

   typedef struct packed {
      logic [15:0] rsvd_hi;
      logic [7:0]  prescale;
      logic [4:0]  rsvd_lo;
      logic        irq_en;
      logic        autoreload;
      logic        en;
   } ctrl_t;

   typedef enum logic {
      TMR_IDLE = 1'b0,
      TMR_RUN  = 1'b1
   } tmr_state_t;

   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/sigma_timer_prescaler.sv
// Free-running divider: emits a one-cycle tick every div_i+1 enabled cycles.
module sigma_timer_prescaler
   import sigma_timer_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             arst_n_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] div_i,
   output logic             tick_o
);

   logic [WIDTH-1:0] cnt_q;

   // A clear on the same edge swallows the tick so a COUNT write is never decremented.
   assign tick_o = en_i & ~clr_i & (cnt_q == div_i);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         cnt_q <= '0;
      end else if (!en_i || clr_i || tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/sigma_xif_timer.sv
// Prescaled down-counting timer on the xif request/response bus with
// optional auto-reload, sticky expiry flag and level interrupt.
module sigma_xif_timer
   import sigma_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h8000_0010,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned PRESCALE_WIDTH = 8
) (
   input  logic        clk_i,
   input  logic        arst_n_i,
   input  logic        bus_req_i,
   input  logic        bus_we_i,
   input  logic [31:0] bus_addr_bi,
   input  logic [3:0]  bus_be_bi,
   input  logic [31:0] bus_wdata_bi,
   output logic        bus_ack_o,
   output logic        bus_resp_o,
   output logic [31:0] bus_rdata_bo,
   output logic        irq_o
);

   tmr_state_t                state_q, state_d;
   logic                      autoreload_q, autoreload_d;
   logic                      irq_en_q, irq_en_d;
   logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
   logic [CNT_WIDTH-1:0]      load_q, load_d;
   logic [CNT_WIDTH-1:0]      count_q, count_d;
   logic                      expired_q, expired_d;
   logic                      resp_q;
   logic [31:0]               rdata_q, rdata_d;

   logic        hit, rd_acc, wr_acc;
   logic [3:0]  ofs;
   logic        wr_ctrl, wr_load, wr_count, wr_status;
   logic        tick, expiry, dec;
   ctrl_t       ctrl_rd, ctrl_new;
   logic [31:0] reg_rd;
   logic        unused_bits;

   assign bus_ack_o = bus_req_i;
   assign hit       = (bus_addr_bi[31:4] == BASE_ADDR[31:4]);
   assign ofs       = {bus_addr_bi[3:2], 2'b00};
   assign rd_acc    = bus_req_i & ~bus_we_i & hit;
   assign wr_acc    = bus_req_i &  bus_we_i & hit;
   assign wr_ctrl   = wr_acc & (ofs == OFS_CTRL);
   assign wr_load   = wr_acc & (ofs == OFS_LOAD);
   assign wr_count  = wr_acc & (ofs == OFS_COUNT);
   assign wr_status = wr_acc & (ofs == OFS_STATUS);

   sigma_timer_prescaler #(
      .WIDTH (PRESCALE_WIDTH)
   ) u_prescaler (
      .clk_i    (clk_i),
      .arst_n_i (arst_n_i),
      .en_i     (state_q == TMR_RUN),
      .clr_i    (wr_count),
      .div_i    (prescale_q),
      .tick_o   (tick)
   );

   assign expiry = tick & (count_q == '0);
   assign dec    = tick & (count_q != '0);

   always_comb begin
      ctrl_rd            = '0;
      ctrl_rd.en         = (state_q == TMR_RUN);
      ctrl_rd.autoreload = autoreload_q;
      ctrl_rd.irq_en     = irq_en_q;
      ctrl_rd.prescale   = 8'(prescale_q);
      unique case (ofs)
         OFS_CTRL:  reg_rd = ctrl_rd;
         OFS_LOAD:  reg_rd = 32'(load_q);
         OFS_COUNT: reg_rd = 32'(count_q);
         default:   reg_rd = {31'b0, expired_q};
      endcase
   end

   assign ctrl_new    = ctrl_t'(be_merge(ctrl_rd, bus_wdata_bi, bus_be_bi));
   assign unused_bits = ^{bus_addr_bi[1:0], ctrl_new};

   always_comb begin
      state_d      = state_q;
      autoreload_d = autoreload_q;
      irq_en_d     = irq_en_q;
      prescale_d   = prescale_q;
      load_d       = load_q;
      count_d      = count_q;
      expired_d    = expired_q;
      rdata_d      = rd_acc ? reg_rd : '0;

      // Clear first so a simultaneous expiry keeps the flag set.
      if (wr_status && bus_be_bi[0] && bus_wdata_bi[0]) expired_d = 1'b0;
      if (expiry) expired_d = 1'b1;

      if (wr_count) begin
         count_d = CNT_WIDTH'(be_merge(32'(count_q), bus_wdata_bi, bus_be_bi));
      end else if (dec) begin
         count_d = count_q - CNT_WIDTH'(1);
      end else if (expiry && autoreload_q) begin
         count_d = load_q;
      end

      if (expiry && !autoreload_q) state_d = TMR_IDLE;

      // A written EN lane overrides the one-shot stop decided above.
      if (wr_ctrl) begin
         autoreload_d = ctrl_new.autoreload;
         irq_en_d     = ctrl_new.irq_en;
         prescale_d   = ctrl_new.prescale[PRESCALE_WIDTH-1:0];
         if (bus_be_bi[0]) state_d = ctrl_new.en ? TMR_RUN : TMR_IDLE;
      end

      if (wr_load) load_d = CNT_WIDTH'(be_merge(32'(load_q), bus_wdata_bi, bus_be_bi));
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q      <= TMR_IDLE;
         autoreload_q <= 1'b0;
         irq_en_q     <= 1'b0;
         prescale_q   <= '0;
         load_q       <= '0;
         count_q      <= '0;
         expired_q    <= 1'b0;
         resp_q       <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         autoreload_q <= autoreload_d;
         irq_en_q     <= irq_en_d;
         prescale_q   <= prescale_d;
         load_q       <= load_d;
         count_q      <= count_d;
         expired_q    <= expired_d;
         resp_q       <= rd_acc;
         rdata_q      <= rdata_d;
      end
   end

   assign bus_resp_o   = resp_q;
   assign bus_rdata_bo = rdata_q;
   assign irq_o        = expired_q & irq_en_q;

endmodule

// File: tb/tb_sigma_xif_timer.sv
// Self-checking bench: directed scenarios plus randomized bus traffic
// compared every cycle against a transaction-level timer model.
module tb_sigma_xif_timer;

   localparam logic [31:0] BASE = 32'h8000_0010;

   logic        clk_i = 1'b0;
   logic        arst_n_i = 1'b0;
   logic        bus_req_i = 1'b0;
   logic        bus_we_i = 1'b0;
   logic [31:0] bus_addr_bi = '0;
   logic [3:0]  bus_be_bi = '0;
   logic [31:0] bus_wdata_bi = '0;
   logic        bus_ack_o, bus_resp_o, irq_o;
   logic [31:0] bus_rdata_bo;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model state
   logic        m_en, m_ar, m_ie, m_exp, m_resp;
   logic [7:0]  m_ps;
   logic [31:0] m_load, m_count, m_rdata;
   int          m_phase;

   sigma_xif_timer #(
      .BASE_ADDR      (BASE),
      .CNT_WIDTH      (32),
      .PRESCALE_WIDTH (8)
   ) dut (
      .clk_i        (clk_i),
      .arst_n_i     (arst_n_i),
      .bus_req_i    (bus_req_i),
      .bus_we_i     (bus_we_i),
      .bus_addr_bi  (bus_addr_bi),
      .bus_be_bi    (bus_be_bi),
      .bus_wdata_bi (bus_wdata_bi),
      .bus_ack_o    (bus_ack_o),
      .bus_resp_o   (bus_resp_o),
      .bus_rdata_bo (bus_rdata_bo),
      .irq_o        (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (o & ~mask) | (n & mask);
   endfunction

   function automatic logic [31:0] model_reg(input logic [1:0] o);
      case (o)
         2'd0:    return {16'h0, m_ps, 5'h0, m_ie, m_ar, m_en};
         2'd1:    return m_load;
         2'd2:    return m_count;
         default: return {31'h0, m_exp};
      endcase
   endfunction

   task automatic model_reset();
      m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_resp = 0;
      m_ps = 0; m_load = 0; m_count = 0; m_rdata = 0; m_phase = 0;
   endtask

   // One clock edge of the timer as the register description states it.
   task automatic model_edge(input logic req, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd);
      logic hit, wr, cnt_wr, tick;
      logic [1:0] o;
      logic [31:0] nc;
      hit    = (addr[31:4] == BASE[31:4]);
      o      = addr[3:2];
      wr     = req && we && hit;
      cnt_wr = wr && (o == 2'd2);
      m_resp  = req && !we && hit;
      m_rdata = m_resp ? model_reg(o) : 32'h0;
      tick = m_en && (m_phase == int'(m_ps)) && !cnt_wr;
      if (!m_en || tick || cnt_wr) m_phase = 0;
      else m_phase = (m_phase + 1) % 256;
      if (wr && o == 2'd3 && be[0] && wd[0]) m_exp = 0;
      if (cnt_wr) begin
         m_count = lane_merge(m_count, wd, be);
      end else if (tick) begin
         if (m_count != 0) m_count = m_count - 1;
         else begin
            m_exp = 1;
            if (m_ar) m_count = m_load;
            else m_en = 0;
         end
      end
      if (wr && o == 2'd0) begin
         nc = lane_merge(model_reg(2'd0), wd, be);
         m_ar = nc[1];
         m_ie = nc[2];
         m_ps = nc[15:8];
         if (be[0]) m_en = nc[0];
      end
      if (wr && o == 2'd1) m_load = lane_merge(m_load, wd, be);
   endtask

   // Called at posedge+1; returns at the following posedge+1.
   task automatic cycle(input logic req, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
      bus_req_i = req; bus_we_i = we; bus_addr_bi = addr; bus_be_bi = be; bus_wdata_bi = wd;
      #1;
      check("ack", 32'(bus_ack_o), 32'(req));
      model_edge(req, we, addr, be, wd);
      @(posedge clk_i);
      #1;
      check("resp", 32'(bus_resp_o), 32'(m_resp));
      check("rdata", bus_rdata_bo, m_rdata);
      check("irq", 32'(irq_o), 32'(m_exp & m_ie));
      bus_req_i = 0; bus_we_i = 0; bus_be_bi = 0;
   endtask

   task automatic wr(input logic [3:0] ofs, input logic [31:0] d, input logic [3:0] be);
      cycle(1'b1, 1'b1, BASE + 32'(ofs), be, d);
   endtask

   task automatic rd(input logic [3:0] ofs, output logic [31:0] d);
      cycle(1'b1, 1'b0, BASE + 32'(ofs), 4'h0, 32'h0);
      d = bus_rdata_bo;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   logic [31:0] d;
   logic [31:0] ar_exp [5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd3};

   initial begin
      model_reset();
      #22 arst_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Reset state
      for (int unsigned i = 0; i < 4; i++) begin
         rd(4'(i * 4), d);
         check("reset_rd", d, 32'h0);
         check("reset_resp", 32'(bus_resp_o), 32'h1);
      end
      check("reset_irq", 32'(irq_o), 32'h0);

      // Out-of-window read
      cycle(1'b1, 1'b0, BASE + 32'h20, 4'h0, 32'h0);
      check("miss_resp", 32'(bus_resp_o), 32'h0);

      // Auto-reload with prescale 0
      wr(4'h4, 32'd3, 4'hF);
      wr(4'h8, 32'd3, 4'hF);
      wr(4'h0, 32'h7, 4'hF);
      for (int unsigned i = 0; i < 5; i++) begin
         rd(4'h8, d);
         check("ar_count", d, ar_exp[i]);
      end
      check("ar_irq_high", 32'(irq_o), 32'h1);
      rd(4'hC, d);
      check("ar_status", d, 32'h1);
      wr(4'hC, 32'h1, 4'hF);
      check("w1c_irq_low", 32'(irq_o), 32'h0);
      wr(4'h0, 32'h0, 4'hF);
      wr(4'hC, 32'h1, 4'hF);

      // One-shot, prescale 4
      wr(4'h8, 32'd2, 4'hF);
      wr(4'h0, 32'h401, 4'hF);
      idle(13);
      rd(4'hC, d);
      check("os_status_pre", d, 32'h0);
      rd(4'h0, d);
      check("os_ctrl_pre", d, 32'h401);
      rd(4'hC, d);
      check("os_status_post", d, 32'h1);
      rd(4'h0, d);
      check("os_ctrl_post", d, 32'h400);
      rd(4'h8, d);
      check("os_count", d, 32'h0);
      check("os_irq", 32'(irq_o), 32'h0);
      wr(4'hC, 32'h1, 4'hF);

      // Byte enables
      wr(4'h8, 32'hAABB_CCDD, 4'hF);
      wr(4'h8, 32'h1122_3344, 4'b0101);
      rd(4'h8, d);
      check("be_merge", d, 32'hAA22_CC44);

      // STATUS W1C on the expiry edge
      wr(4'h8, 32'h0, 4'hF);
      wr(4'h0, 32'h1, 4'hF);
      wr(4'hC, 32'h1, 4'hF);
      rd(4'hC, d);
      check("w1c_collide", d, 32'h1);
      wr(4'hC, 32'h1, 4'hF);

      // COUNT write on a tick edge
      wr(4'h8, 32'd20, 4'hF);
      wr(4'h0, 32'h301, 4'hF);
      idle(3);
      wr(4'h8, 32'd9, 4'hF);
      wr(4'h0, 32'h0, 4'hF);
      rd(4'h8, d);
      check("cnt_wr_tick", d, 32'd9);

      // Reset mid-count with a read response outstanding
      wr(4'h4, 32'd5, 4'hF);
      wr(4'h8, 32'd50, 4'hF);
      wr(4'h0, 32'h7, 4'hF);
      idle(4);
      cycle(1'b1, 1'b0, BASE + 32'h8, 4'h0, 32'h0);
      arst_n_i = 1'b0;
      #1;
      check("rst_resp", 32'(bus_resp_o), 32'h0);
      check("rst_rdata", bus_rdata_bo, 32'h0);
      check("rst_irq", 32'(irq_o), 32'h0);
      model_reset();
      #2 arst_n_i = 1'b1;
      @(posedge clk_i);
      #1;
      for (int unsigned i = 0; i < 4; i++) begin
         rd(4'(i * 4), d);
         check("post_rst_rd", d, 32'h0);
      end

      // Randomized traffic
      for (int unsigned n = 0; n < 3000; n++) begin
         int unsigned r, o;
         logic [31:0] wdat;
         logic [3:0]  be;
         r = $urandom_range(0, 99);
         o = $urandom_range(0, 3);
         be = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom);
         case (o)
            0: wdat = {16'($urandom), 8'($urandom_range(0, 3)), 5'($urandom),
                       1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0)};
            1, 2: wdat = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 12));
            default: wdat = $urandom;
         endcase
         if (r < 35) begin
            rd(4'(o * 4), d);
         end else if (r < 42) begin
            cycle(1'b1, 1'($urandom), BASE + 32'h10 * 32'($urandom_range(1, 15)) + 32'(o * 4),
                  be, wdat);
         end else if (r < 70) begin
            wr(4'(o * 4), wdat, be);
         end else begin
            idle(1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
